icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
//  Direct-mapped, read-only instruction cache between iFetch and memCtrl.
//  iFetch issues a fetch address. A hit returns the 32-bit instruction one cycle later.
//  A miss fills the whole line from memCtrl one word at a time, then returns the requested word.
//  roll_back aborts any outstanding fetch or fill.
// PARAMETERS
//  LINES       64   number of lines; power of 2, >=2
//  LINE_WORDS  4    32-bit words per line; power of 2, >=2
// PORTS
//  clk               in   1   system clock
//  rst_in            in   1   reset, asynchronous, active-high
//  rdy_in            in   1   global ready; low freezes all state
//  roll_back         in   1   ROB misprediction flush
//  if_a_en           in   1   fetch request valid
//  if_ain            in   32  fetch byte address; bits [1:0] ignored
//  if_instr_out_en   out  1   one-cycle pulse: if_instr_out valid
//  if_instr_out      out  32  instruction for the accepted request
//  if_busy           out  1   request outstanding; new requests ignored
//  mc_a_en           out  1   word read request to memCtrl
//  mc_aout           out  32  word-aligned read address
//  mc_instr_in_en    in   1   memCtrl word-return pulse
//  mc_instr_in       in   32  returned word, little-endian assembled
// BEHAVIOUR
//  Address split: off=[OB-1:2], OB=2+log2(LINE_WORDS); idx=[OB+IB-1:OB], IB=log2(LINES);
//   tag=[31:OB+IB].
//  Reset (async): all valid bits=0; state=IDLE; every output=0.
//  Tag/data arrays are not reset.
//  rdy_in=0: no state, array or output register changes; registered outputs hold value.
//  States: IDLE, FILL, RESP.
//  IDLE, if_a_en=1, roll_back=0: latch addr and set if_busy.
//   Hit (valid[idx] && tag match): next cycle if_instr_out_en=1 with data; stay IDLE; if_busy=0.
//   Miss: clear valid[idx]; go to FILL with word counter w=0.
//  FILL: drive mc_a_en=1, mc_aout={tag,idx,w,2'b00}.
//   On each mc_instr_in_en: write word w and increment w.
//   mc_aout advances in the same cycle; memCtrl treats each address change as a new request.
//   After word LINE_WORDS-1 is written: set valid[idx] and tag[idx];
//    drop mc_a_en next cycle; go to RESP.
//  RESP: if_instr_out_en=1 with the requested word (critical word not forwarded early);
//   clear if_busy; go to IDLE.
//  Latency: hit = 1 cycle; miss = LINE_WORDS memCtrl returns + 1 cycle.
//  if_instr_out_en is a 1-cycle pulse; if_instr_out holds its value until the next pulse.
//  if_a_en while if_busy=1 is ignored; iFetch must wait for the pulse.
//  roll_back (any state, rdy_in=1): next cycle state=IDLE, if_busy=0,
//   mc_a_en=0, if_instr_out_en=0.
//   Any same-cycle if_a_en or mc_instr_in_en is discarded.
//   A partially filled line stays invalid.
//  roll_back together with a hit: the pulse is suppressed.
//  Back-to-back hits: a request may be accepted in the same cycle the previous pulse is driven.
//  Fill to the same idx as a later hit is safe: valid is set only after the line is complete.
//  Wrap: w wraps mod LINE_WORDS; addresses never cross the line boundary.
// STRUCTURE
//  param.v: ICACHE_LINES, ICACHE_LINE_WORDS, derived OFF/IDX/TAG ranges, state encodings.
//  One sub-module, icache_array: tag+valid+data storage.
//   Combinational read by idx; synchronous word write; valid set/clear ports.
//   Valid bits have async reset.
//  icache top holds the FSM, request latch, word counter and output registers.
// TESTING
//  Cold miss at 0x0000_1004 -> mc_aout 0x1000,0x1004,0x1008,0x100C in order;
//   then pulse with word@0x1004; total latency 4 returns + 1.
//  Repeat 0x1004 then 0x100C -> each pulse 1 cycle after request; mc_a_en stays 0.
//  Conflict: 0x1004, then 0x1404 (same idx, LINES=64) -> refill;
//   then 0x1004 -> miss again.
//  roll_back after 2nd fill word -> next cycle IDLE, mc_a_en=0, no pulse;
//   re-request same address -> full 4-word refill.
//  rdy_in=0 for 5 cycles mid-fill, with mc_instr_in_en held 0 -> state and w unchanged;
//   resume completes correctly.
//  rst_in asserted mid-fill -> outputs 0 immediately; any prior hit address now misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared icache geometry defaults and FSM state encoding.
package icache_pkg;
    localparam int ICACHE_LINES      = 64;
    localparam int ICACHE_LINE_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage: combinational read by index, synchronous word and tag writes.
// Only the valid bits are reset; tag and data contents are don't-care until filled.
module icache_array import icache_pkg::*; #(
    parameter int LINES      = ICACHE_LINES,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int IW         = $clog2(LINES),
    parameter int OW         = $clog2(LINE_WORDS),
    parameter int TW         = 32 - 2 - OW - IW
) (
    input  logic          clk,
    input  logic          rst_in,
    input  logic [IW-1:0] i_ridx,
    input  logic [OW-1:0] i_roff,
    output logic          o_rvld,
    output logic [TW-1:0] o_rtag,
    output logic [31:0]   o_rdat,
    input  logic          i_we,
    input  logic [IW-1:0] i_widx,
    input  logic [OW-1:0] i_woff,
    input  logic [31:0]   i_wdat,
    input  logic          i_vset,
    input  logic [TW-1:0] i_wtag,
    input  logic          i_vclr,
    input  logic [IW-1:0] i_cidx
);
    logic [LINES-1:0] r_vld;
    logic [TW-1:0]    r_tag [LINES];
    logic [31:0]      r_dat [LINES*LINE_WORDS];

    assign o_rvld = r_vld[i_ridx];
    assign o_rtag = r_tag[i_ridx];
    assign o_rdat = r_dat[{i_ridx, i_roff}];

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_vld <= '0;
        end else begin
            if (i_vclr) r_vld[i_cidx] <= 1'b0;
            if (i_vset) r_vld[i_widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we)   r_dat[{i_widx, i_woff}] <= i_wdat;
        if (i_vset) r_tag[i_widx]           <= i_wtag;
    end
endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: hit answers 1 cycle after request, miss after a full line fill + 1.
// Requests are ignored while if_busy; rdy_in low freezes everything; roll_back aborts any fetch or fill.
module icache import icache_pkg::*; #(
    parameter int LINES      = ICACHE_LINES,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        roll_back,
    input  logic        if_a_en,
    input  logic [31:0] if_ain,
    output logic        if_instr_out_en,
    output logic [31:0] if_instr_out,
    output logic        if_busy,
    output logic        mc_a_en,
    output logic [31:0] mc_aout,
    input  logic        mc_instr_in_en,
    input  logic [31:0] mc_instr_in
);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int IW = $clog2(LINES);
    localparam int OB = 2 + OW;
    localparam int TW = 32 - OB - IW;

    state_t        r_state, w_state_nxt;
    logic [31:2]   r_addr;
    logic [OW-1:0] r_w;
    logic          r_busy, r_out_en;
    logic [31:0]   r_out;

    logic [IW-1:0] w_ridx;
    logic [OW-1:0] w_roff;
    logic          w_rvld, w_hit, w_req, w_fill_ret, w_last;
    logic [TW-1:0] w_rtag;
    logic [31:0]   w_rdat;
    logic          w_unused_bits;

    assign w_unused_bits = ^if_ain[1:0];

    // Lookup uses the live request in IDLE, otherwise the latched one.
    assign w_ridx     = (r_state == ST_IDLE) ? if_ain[OB+IW-1:OB] : r_addr[OB+IW-1:OB];
    assign w_roff     = (r_state == ST_IDLE) ? if_ain[OB-1:2]     : r_addr[OB-1:2];
    assign w_hit      = w_rvld && (w_rtag == if_ain[31:OB+IW]);
    assign w_req      = (r_state == ST_IDLE) && if_a_en && !roll_back;
    assign w_fill_ret = (r_state == ST_FILL) && mc_instr_in_en && !roll_back;
    assign w_last     = w_fill_ret && (r_w == OW'(LINE_WORDS - 1));

    icache_array #(.LINES(LINES), .LINE_WORDS(LINE_WORDS)) u_array (
        .clk    (clk),
        .rst_in (rst_in),
        .i_ridx (w_ridx),
        .i_roff (w_roff),
        .o_rvld (w_rvld),
        .o_rtag (w_rtag),
        .o_rdat (w_rdat),
        .i_we   (rdy_in && w_fill_ret),
        .i_widx (r_addr[OB+IW-1:OB]),
        .i_woff (r_w),
        .i_wdat (mc_instr_in),
        .i_vset (rdy_in && w_last),
        .i_wtag (r_addr[31:OB+IW]),
        .i_vclr (rdy_in && w_req && !w_hit),
        .i_cidx (if_ain[OB+IW-1:OB])
    );

    always_comb begin
        w_state_nxt = r_state;
        if (roll_back) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (if_a_en && !w_hit) w_state_nxt = ST_FILL;
                ST_FILL: if (w_last) w_state_nxt = ST_RESP;
                ST_RESP: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_w      <= '0;
            r_busy   <= 1'b0;
            r_out_en <= 1'b0;
            r_out    <= '0;
        end else if (rdy_in) begin
            r_state  <= w_state_nxt;
            r_out_en <= 1'b0;
            if (roll_back) begin
                r_busy <= 1'b0;
                r_w    <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: if (if_a_en) begin
                        r_addr <= if_ain[31:2];
                        if (w_hit) begin
                            r_out_en <= 1'b1;
                            r_out    <= w_rdat;
                            r_busy   <= 1'b0;
                        end else begin
                            r_busy <= 1'b1;
                            r_w    <= '0;
                        end
                    end
                    ST_FILL: if (mc_instr_in_en) begin
                        r_w <= r_w + OW'(1);
                        // The requested word may be the one arriving on this very edge.
                        if (w_last) begin
                            r_out_en <= 1'b1;
                            r_out    <= (w_roff == OW'(LINE_WORDS - 1)) ? mc_instr_in : w_rdat;
                        end
                    end
                    ST_RESP: r_busy <= 1'b0;
                    default: r_busy <= 1'b0;
                endcase
            end
        end
    end

    assign if_instr_out_en = r_out_en;
    assign if_instr_out    = r_out;
    assign if_busy         = r_busy;
    assign mc_a_en         = (r_state == ST_FILL);
    assign mc_aout         = (r_state == ST_FILL) ? {r_addr[31:OB], r_w, 2'b00} : 32'h0;
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: table of fetches with expected hit/miss, plus hand sequences for
// roll_back, rdy_in stall, reset mid-fill and back-to-back hits.
module tb_icache;
    logic        clk = 1'b0;
    logic        rst_in, rdy_in, roll_back, if_a_en;
    logic [31:0] if_ain;
    logic        if_instr_out_en, if_busy, mc_a_en, mc_instr_in_en;
    logic [31:0] if_instr_out, mc_aout, mc_instr_in;

    int n_tests = 0;
    int n_fail  = 0;

    icache dut (
        .clk             (clk),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .roll_back       (roll_back),
        .if_a_en         (if_a_en),
        .if_ain          (if_ain),
        .if_instr_out_en (if_instr_out_en),
        .if_instr_out    (if_instr_out),
        .if_busy         (if_busy),
        .mc_a_en         (mc_a_en),
        .mc_aout         (mc_aout),
        .mc_instr_in_en  (mc_instr_in_en),
        .mc_instr_in     (mc_instr_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          miss;
    } vec_t;
    vec_t vt [9];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one fetch, serve memCtrl with one return per cycle, check addresses, latency and data.
    task automatic fetch(input logic [31:0] a, input bit exp_miss);
        int cyc;
        int nret;
        logic [31:0] exp_ma;
        @(negedge clk);
        if_a_en = 1'b1;
        if_ain  = a;
        @(negedge clk);
        if_a_en = 1'b0;
        cyc  = 1;
        nret = 0;
        chk("busy_after_req", 32'(if_busy), 32'(exp_miss));
        chk("mc_a_en_after_req", 32'(mc_a_en), 32'(exp_miss));
        while (!if_instr_out_en && cyc < 50) begin
            if (mc_a_en) begin
                exp_ma = {a[31:4], nret[1:0], 2'b00};
                chk("mc_aout_order", mc_aout, exp_ma);
                mc_instr_in_en = 1'b1;
                mc_instr_in    = mem_word(mc_aout);
                nret++;
            end
            @(negedge clk);
            mc_instr_in_en = 1'b0;
            cyc++;
        end
        chk("pulse_seen", 32'(if_instr_out_en), 32'd1);
        chk("latency", 32'(cyc), exp_miss ? 32'd5 : 32'd1);
        chk("mc_returns", 32'(nret), exp_miss ? 32'd4 : 32'd0);
        chk("instr_data", if_instr_out, mem_word({a[31:2], 2'b00}));
    endtask

    initial begin
        vt[0] = '{32'h0000_1004, 1'b1};
        vt[1] = '{32'h0000_1004, 1'b0};
        vt[2] = '{32'h0000_100C, 1'b0};
        vt[3] = '{32'h0000_1404, 1'b1};
        vt[4] = '{32'h0000_1004, 1'b1};
        vt[5] = '{32'h0000_1008, 1'b0};
        vt[6] = '{32'h0000_2010, 1'b1};
        vt[7] = '{32'h0000_2014, 1'b0};
        vt[8] = '{32'h0000_1404, 1'b1};

        rst_in = 1'b1; rdy_in = 1'b1; roll_back = 1'b0; if_a_en = 1'b0;
        if_ain = '0; mc_instr_in_en = 1'b0; mc_instr_in = '0;
        #12;
        chk("rst_pulse", 32'(if_instr_out_en), 32'd0);
        chk("rst_instr", if_instr_out, 32'd0);
        chk("rst_busy", 32'(if_busy), 32'd0);
        chk("rst_mc_a_en", 32'(mc_a_en), 32'd0);
        chk("rst_mc_aout", mc_aout, 32'd0);
        @(negedge clk);
        rst_in = 1'b0;

        for (int i = 0; i < 9; i++) fetch(vt[i].addr, vt[i].miss);

        // Back-to-back hits: next request driven in the pulse cycle.
        @(negedge clk);
        if_a_en = 1'b1; if_ain = 32'h0000_1404;
        @(negedge clk);
        chk("b2b_pulse0", 32'(if_instr_out_en), 32'd1);
        chk("b2b_data0", if_instr_out, mem_word(32'h0000_1404));
        if_ain = 32'h0000_1408;
        @(negedge clk);
        if_a_en = 1'b0;
        chk("b2b_pulse1", 32'(if_instr_out_en), 32'd1);
        chk("b2b_data1", if_instr_out, mem_word(32'h0000_1408));
        @(negedge clk);
        chk("b2b_pulse_end", 32'(if_instr_out_en), 32'd0);

        // roll_back after two fill words, with a third return discarded.
        if_a_en = 1'b1; if_ain = 32'h0000_1004;
        @(negedge clk);
        if_a_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mc_instr_in_en = 1'b1; mc_instr_in = mem_word(mc_aout);
            @(negedge clk);
        end
        chk("rb_pre_aout", mc_aout, 32'h0000_1008);
        roll_back = 1'b1; mc_instr_in_en = 1'b1; mc_instr_in = mem_word(mc_aout);
        @(negedge clk);
        roll_back = 1'b0; mc_instr_in_en = 1'b0;
        chk("rb_mc_a_en", 32'(mc_a_en), 32'd0);
        chk("rb_busy", 32'(if_busy), 32'd0);
        chk("rb_pulse", 32'(if_instr_out_en), 32'd0);
        repeat (3) @(negedge clk);
        chk("rb_no_late_pulse", 32'(if_instr_out_en | mc_a_en), 32'd0);
        fetch(32'h0000_1004, 1'b1);

        // roll_back together with a hit suppresses the pulse.
        @(negedge clk);
        if_a_en = 1'b1; if_ain = 32'h0000_1004; roll_back = 1'b1;
        @(negedge clk);
        if_a_en = 1'b0; roll_back = 1'b0;
        chk("rb_hit_pulse", 32'(if_instr_out_en), 32'd0);
        chk("rb_hit_busy", 32'(if_busy), 32'd0);
        fetch(32'h0000_1004, 1'b0);

        // rdy_in low for 5 cycles mid-fill.
        @(negedge clk);
        if_a_en = 1'b1; if_ain = 32'h0000_3028;
        @(negedge clk);
        if_a_en = 1'b0;
        mc_instr_in_en = 1'b1; mc_instr_in = mem_word(mc_aout);
        @(negedge clk);
        mc_instr_in_en = 1'b0; rdy_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_aout", mc_aout, 32'h0000_3024);
            chk("stall_a_en", 32'(mc_a_en), 32'd1);
        end
        rdy_in = 1'b1;
        for (int k = 1; k < 4; k++) begin
            chk("stall_resume_aout", mc_aout, 32'h0000_3020 + 32'(k * 4));
            mc_instr_in_en = 1'b1; mc_instr_in = mem_word(mc_aout);
            @(negedge clk);
            mc_instr_in_en = 1'b0;
        end
        chk("stall_pulse", 32'(if_instr_out_en), 32'd1);
        chk("stall_data", if_instr_out, mem_word(32'h0000_3028));
        fetch(32'h0000_302C, 1'b0);

        // Asynchronous reset mid-fill clears outputs at once and invalidates all lines.
        @(negedge clk);
        if_a_en = 1'b1; if_ain = 32'h0000_4030;
        @(negedge clk);
        if_a_en = 1'b0;
        mc_instr_in_en = 1'b1; mc_instr_in = mem_word(mc_aout);
        @(negedge clk);
        mc_instr_in_en = 1'b0;
        #2 rst_in = 1'b1;
        #1;
        chk("mid_rst_a_en", 32'(mc_a_en), 32'd0);
        chk("mid_rst_aout", mc_aout, 32'd0);
        chk("mid_rst_busy", 32'(if_busy), 32'd0);
        chk("mid_rst_instr", if_instr_out, 32'd0);
        @(negedge clk);
        rst_in = 1'b0;
        fetch(32'h0000_1004, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
